// File: rtl/ram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// ram_fifo_pkg
// Shared definitions for the RAM-backed FIFO controller: default geometry of
// the stream/RAM word and the two-state read sequencer encoding.
// Ports: none (package).
// -----------------------------------------------------------------------------
package ram_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    // ST_RD_WAIT covers the cycle in which the registered RAM read data is
    // not yet visible; the output register loads at the end of it.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/ram_fifo_if.sv
// -----------------------------------------------------------------------------
// ram_fifo_if
// Bundles the upstream (s_*) and downstream (m_*) valid/ready streams plus the
// occupancy status outputs of the FIFO controller.
// Modports:
//   slave  - controller side: takes s_valid/s_data/m_ready, drives
//            s_ready/m_valid/m_data/level/peak_level
//   master - environment side: the mirror image
// -----------------------------------------------------------------------------
interface ram_fifo_if
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W:0]   level;
    logic [ADDR_W:0]   peak_level;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, level, peak_level
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, level, peak_level
    );

endinterface

// File: rtl/ram_fifo_mem.sv
// -----------------------------------------------------------------------------
// ram_fifo_mem
// Single-port synchronous RAM, 2**ADDR_W words of DATA_W bits.
// A write happens at the edge when i_we=1; with i_we=0 and i_re=1 the addressed
// word is registered into o_dout and is visible the following cycle.
// Ports:
//   clk     in   rising-edge clock
//   i_we    in   write enable (has priority over i_re)
//   i_re    in   read enable
//   i_addr  in   ADDR_W word address
//   i_din   in   DATA_W write data
//   o_dout  out  DATA_W registered read data
// -----------------------------------------------------------------------------
module ram_fifo_mem
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_dout;

    // NOTE: the array and its read register have no reset so they map onto a
    // RAM macro; stale contents are unreachable because the pointers reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_din;
        end else if (i_re) begin
            r_dout <= r_mem[i_addr];
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// ram_fifo_ctrl
// FIFO controller in front of a single-port synchronous RAM. Writes and reads
// share the one address port (reads win), and a one-entry output register
// holds the word presented downstream. Capacity is 2**ADDR_W + 1 words.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    ram_fifo_if.slave: s_valid/s_ready/s_data in, m_valid/m_ready/
//          m_data out, level (RAM count + output register), peak_level
// Build option:
//   RAM_FIFO_PEAK_EN - when defined, peak_level tracks max(level) since reset;
//                      otherwise peak_level is tied to 0.
// -----------------------------------------------------------------------------
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic       clk,
    input  logic       rst_n,
    ram_fifo_if.slave  bus
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(2**ADDR_W);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_ram_count;
    logic                r_m_valid;
    logic [DATA_W-1:0]   r_m_data;

    logic                w_rd_issue;
    logic                w_s_ready;
    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_ram_dout;
    logic [ADDR_W:0]     w_level;

    // Read sequencer: a read may start only when the output register will be
    // free at the edge the data lands (empty now, or being popped now).
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_issue  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((r_ram_count != '0) && (!r_m_valid || bus.m_ready)) begin
                    w_rd_issue  = 1'b1;
                    w_state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Writes only take the port when no read claims it; never looks at s_valid.
    assign w_s_ready = rst_n && (r_ram_count < DEPTH_CNT) && !w_rd_issue;
    assign w_wr_en   = bus.s_valid && w_s_ready;
    assign w_addr    = w_rd_issue ? r_rd_ptr : r_wr_ptr;

    ram_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .i_we   (w_wr_en),
        .i_re   (w_rd_issue),
        .i_addr (w_addr),
        .i_din  (bus.s_data),
        .o_dout (w_ram_dout)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ram_count <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Read and write are mutually exclusive on the port.
            case ({w_wr_en, w_rd_issue})
                2'b10:   r_ram_count <= r_ram_count + 1'b1;
                2'b01:   r_ram_count <= r_ram_count - 1'b1;
                default: r_ram_count <= r_ram_count;
            endcase
            // A load from ST_RD_WAIT wins over a same-edge pop, keeping m_valid.
            if (r_state == ST_RD_WAIT) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_ram_dout;
            end else if (r_m_valid && bus.m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign w_level = r_ram_count + {{ADDR_W{1'b0}}, r_m_valid};

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign bus.level   = w_level;

`ifdef RAM_FIFO_PEAK_EN
    logic [ADDR_W:0] r_peak_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak_level <= '0;
        end else if (w_level > r_peak_level) begin
            r_peak_level <= w_level;
        end
    end

    assign bus.peak_level = r_peak_level;
`else
    assign bus.peak_level = '0;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_fifo_ctrl
// Self-checking bench for ram_fifo_ctrl. Inputs change 1 ns after the rising
// edge and outputs are sampled on the falling edge. Accepted words are queued
// and compared against every word popped downstream.
// -----------------------------------------------------------------------------
module tb_ram_fifo_ctrl;
    import ram_fifo_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
`ifdef RAM_FIFO_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ram_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ram_fifo_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    logic [DATA_W-1:0] exp_q[$];

    // Scoreboard: push on upstream handshake, pop/compare on downstream pop.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.s_valid && bus.s_ready) begin
                exp_q.push_back(bus.s_data);
            end
            if (bus.m_valid && bus.m_ready) begin
                checks++;
                pops++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_order: popped m_data=%h, required no word (nothing outstanding)", bus.m_data);
                end else begin
                    logic [DATA_W-1:0] exp_w;
                    exp_w = exp_q.pop_front();
                    if (bus.m_data !== exp_w) begin
                        failures++;
                        $display("FAIL sb_order: popped m_data=%h, required %h", bus.m_data, exp_w);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents consecutive bytes base, base+1, ... until n are accepted.
    task automatic push_words(input logic [DATA_W-1:0] base, input int n);
        int   k     = 0;
        int   guard = 0;
        logic acc;
        bus.s_valid = 1'b1;
        bus.s_data  = base;
        while (k < n && guard < 100) begin
            @(negedge clk);
            acc = bus.s_ready;
            tick();
            guard++;
            if (acc) begin
                k++;
                bus.s_data = base + DATA_W'(k);
            end
        end
        bus.s_valid = 1'b0;
        checks++;
        if (k != n) begin
            failures++;
            $display("FAIL push_%h: accepted %0d words, required %0d", base, k, n);
        end
    endtask

    // Pops everything, then confirms the FIFO is empty and nothing is owed.
    task automatic drain(input string name);
        int quiet = 0;
        int guard = 0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        while (quiet < 2 && guard < 100) begin
            @(negedge clk);
            if (!bus.m_valid && bus.level == 0) quiet++;
            else quiet = 0;
            guard++;
        end
        tick();
        bus.m_ready = 1'b0;
        checks++;
        if (quiet < 2) begin
            failures++;
            $display("FAIL %s_drain_timeout: level=%0d m_valid=%b, required empty within 100 cycles", name, bus.level, bus.m_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0 || bus.level !== '0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_empty: m_valid=%b level=%0d outstanding=%0d, required 0/0/0", name, bus.m_valid, bus.level, exp_q.size());
        end
        tick();
    endtask

    task automatic test_reset();
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        rst_n       = 1'b0;
        #1;
        checks++;
        if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.level !== '0 || bus.peak_level !== '0) begin
            failures++;
            $display("FAIL reset_state: s_ready=%b m_valid=%b level=%0d peak=%0d, required 0/0/0/0", bus.s_ready, bus.m_valid, bus.level, bus.peak_level);
        end
        bus.s_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_s_ready: s_ready=%b while rst_n=0, required 0", bus.s_ready);
        end
        bus.s_valid = 1'b0;
        rst_n       = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0 || bus.level !== '0) begin
            failures++;
            $display("FAIL reset_release: s_ready=%b m_valid=%b level=%0d, required 1/0/0", bus.s_ready, bus.m_valid, bus.level);
        end
        tick();
    endtask

    // AA accepted at edge 0, read issued in cycle 1, load at edge 2, visible cycle 3.
    task automatic test_latency();
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hAA;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_c0: s_ready=%b m_valid=%b, required 1/0", bus.s_ready, bus.m_valid);
        end
        tick();
        bus.s_data = 8'hBB;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b0 || bus.level !== 4'd1 || bus.m_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_c1_issue: s_ready=%b level=%0d m_valid=%b, required 0/1/0", bus.s_ready, bus.level, bus.m_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_c2_wait: s_ready=%b m_valid=%b, required 1/0", bus.s_ready, bus.m_valid);
        end
        tick();
        bus.s_data = 8'hCC;
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hAA || bus.level !== 4'd2 || bus.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL lat_c3_out: m_valid=%b m_data=%h level=%0d s_ready=%b, required 1/aa/2/1", bus.m_valid, bus.m_data, bus.level, bus.s_ready);
        end
        tick();
        bus.s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hAA || bus.level !== 4'd3) begin
            failures++;
            $display("FAIL lat_c4_hold: m_valid=%b m_data=%h level=%0d, required 1/aa/3", bus.m_valid, bus.m_data, bus.level);
        end
        tick();
        drain("latency");
    endtask

    // Nine words fill RAM (8) plus output register (1); the next word is refused.
    task automatic test_full();
        int p0;
        p0 = pops;
        bus.m_ready = 1'b0;
        push_words(8'h10, 9);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.s_ready !== 1'b0 || bus.level !== 4'd9 || bus.m_data !== 8'h10) begin
                failures++;
                $display("FAIL full_hold_%0d: s_ready=%b level=%0d m_data=%h, required 0/9/10", i, bus.s_ready, bus.level, bus.m_data);
            end
            tick();
        end
        bus.s_valid = 1'b0;
        drain("full");
        checks++;
        if (pops - p0 != 9) begin
            failures++;
            $display("FAIL full_pop_count: popped %0d words, required 9", pops - p0);
        end
    endtask

    // Both sides always willing: s_ready alternates 1,0,1,0... from an empty start.
    task automatic test_back_to_back();
        int   p0;
        int   k = 0;
        int   c = 0;
        logic acc;
        logic exp_rdy;
        p0 = pops;
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h30;
        while (k < 20 && c < 100) begin
            @(negedge clk);
            exp_rdy = (c % 2 == 0);
            checks++;
            if (bus.s_ready !== exp_rdy) begin
                failures++;
                $display("FAIL stream_ready_c%0d: s_ready=%b, required %b", c, bus.s_ready, exp_rdy);
            end
            acc = bus.s_ready;
            tick();
            if (acc) begin
                k++;
                bus.s_data = 8'h30 + DATA_W'(k);
            end
            c++;
        end
        bus.s_valid = 1'b0;
        drain("stream");
        checks++;
        if (pops - p0 != 20) begin
            failures++;
            $display("FAIL stream_pop_count: popped %0d words, required 20", pops - p0);
        end
    endtask

    // Push into an empty FIFO: no read that cycle, read issued the next.
    task automatic test_empty_push();
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h55;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL empty_push_c0: s_ready=%b, required 1 (no read issued)", bus.s_ready);
        end
        tick();
        bus.s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b0) begin
            failures++;
            $display("FAIL empty_push_c1: s_ready=%b, required 0 (read issued)", bus.s_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_push_c2: s_ready=%b m_valid=%b, required 1/0", bus.s_ready, bus.m_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h55) begin
            failures++;
            $display("FAIL empty_push_c3: m_valid=%b m_data=%h, required 1/55", bus.m_valid, bus.m_data);
        end
        tick();
        drain("empty_push");
    endtask

    // Reset lands in ST_RD_WAIT; the in-flight word must vanish.
    task automatic test_reset_midflight();
        int p0;
        bus.m_ready = 1'b0;
        push_words(8'h60, 6);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (bus.m_valid !== 1'b0 || bus.level !== '0 || bus.peak_level !== '0 || bus.s_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: m_valid=%b level=%0d peak=%0d s_ready=%b, required 0/0/0/0", bus.m_valid, bus.level, bus.peak_level, bus.s_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        p0 = pops;
        push_words(8'h77, 1);
        drain("rst_mid");
        checks++;
        if (pops - p0 != 1) begin
            failures++;
            $display("FAIL rst_mid_pop_count: popped %0d words, required 1", pops - p0);
        end
    endtask

    // Peak follows level one edge late and holds through the drain.
    task automatic test_peak();
        logic [ADDR_W:0] exp_pk;
        bus.m_ready = 1'b0;
        push_words(8'h80, 6);
        @(negedge clk);
        exp_pk = PEAK_EN ? 4'd5 : 4'd0;
        checks++;
        if (bus.level !== 4'd6 || bus.peak_level !== exp_pk) begin
            failures++;
            $display("FAIL peak_lag: level=%0d peak=%0d, required 6/%0d", bus.level, bus.peak_level, exp_pk);
        end
        tick();
        @(negedge clk);
        exp_pk = PEAK_EN ? 4'd6 : 4'd0;
        checks++;
        if (bus.peak_level !== exp_pk) begin
            failures++;
            $display("FAIL peak_update: peak=%0d, required %0d", bus.peak_level, exp_pk);
        end
        tick();
        drain("peak");
        @(negedge clk);
        checks++;
        if (bus.peak_level !== exp_pk || bus.level !== '0) begin
            failures++;
            $display("FAIL peak_hold: peak=%0d level=%0d, required %0d/0", bus.peak_level, bus.level, exp_pk);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_full();
        test_back_to_back();
        test_empty_push();
        test_reset_midflight();
        test_peak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
